// File: rtl/eth_ctrl_pkg.sv
// Shared constants and state encoding for the Ethernet control-port sender.
package eth_ctrl_pkg;

    localparam int CTRL_NIBBLE_W = 4;
    localparam int CMD_COUNT_W   = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CFG  = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/eth_ctrl_watchdog.sv
// Stall watchdog for the nibble port: counts consecutive stalled cycles and
// flags expiry in the TIMEOUT-th one.
module eth_ctrl_watchdog
    import eth_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_125,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT - 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    // count holds completed stall cycles, so the current one is count+1
    logic [CW-1:0] count;

    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TERM) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERM);

endmodule

// File: rtl/eth_ctrl_sender.sv
// Serializes fabric command words onto the 4-bit control port, MS nibble
// first, and issues start_config pulses on request.
//
// state | meaning
// IDLE  | waiting; cmd_ready high unless a config pulse is pending
// CFG   | start_config held high for START_PULSE cycles
// SEND  | nibbles offered on control_data with control_valid
// GAP   | control_valid low for GAP_CYCLES before returning to IDLE
module eth_ctrl_sender
    import eth_ctrl_pkg::*;
#(
    parameter int CMD_NIBBLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int START_PULSE = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                            clk_125,
    input  logic                            sys_rst_n,
    input  logic [CTRL_NIBBLE_W*CMD_NIBBLES-1:0] cmd_data,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cfg_req,
    output logic                            start_config,
    output logic [CTRL_NIBBLE_W-1:0]        control_data,
    output logic                            control_valid,
    input  logic                            control_ready,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [CMD_COUNT_W-1:0]          cmd_count
);

    localparam int CMD_W   = CTRL_NIBBLE_W * CMD_NIBBLES;
    localparam int NW      = cnt_width(CMD_NIBBLES - 1);
    localparam int TMR_MAX = ((START_PULSE > GAP_CYCLES) ? START_PULSE : GAP_CYCLES) - 1;
    localparam int TW      = cnt_width(TMR_MAX);

    localparam logic [NW-1:0] NIB_LOAD   = NW'(CMD_NIBBLES - 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(START_PULSE - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t        ST_AFTER   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t           state;
    state_t           state_nxt;
    logic             cfg_pend;
    logic             cfg_pend_nxt;
    logic [CMD_W-1:0] shreg;
    logic [NW-1:0]    nib_left;
    logic [TW-1:0]    tmr;
    logic             nib_hs;
    logic             last_hs;
    logic             wd_enable;
    logic             wd_expired;

    assign nib_hs    = control_valid && control_ready;
    assign last_hs   = nib_hs && (nib_left == '0);
    assign wd_enable = control_valid && !control_ready;

    eth_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_125   (clk_125),
        .sys_rst_n (sys_rst_n),
        .clear     (!wd_enable),
        .enable    (wd_enable),
        .expired   (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_pend) begin
                    state_nxt = ST_CFG;
                end else if (cmd_valid && cmd_ready) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_CFG: begin
                if (tmr == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (wd_expired || last_hs) begin
                    state_nxt = ST_AFTER;
                end
            end
            ST_GAP: begin
                if (tmr == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A request arriving on the very edge that ends CFG still wins.
    assign cfg_pend_nxt = cfg_req ||
                          (cfg_pend && !(state == ST_CFG && state_nxt == ST_IDLE));

    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            cfg_pend      <= 1'b0;
            cmd_ready     <= 1'b0;
            start_config  <= 1'b0;
            control_data  <= '0;
            control_valid <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            cmd_count     <= '0;
            shreg         <= '0;
            nib_left      <= '0;
            tmr           <= '0;
        end else begin
            state     <= state_nxt;
            cfg_pend  <= cfg_pend_nxt;
            busy      <= (state_nxt != ST_IDLE);
            cmd_ready <= (state_nxt == ST_IDLE) && !cfg_pend_nxt;

            case (state)
                ST_IDLE: begin
                    if (cfg_pend) begin
                        start_config <= 1'b1;
                        tmr          <= PULSE_LOAD;
                    end else if (cmd_valid && cmd_ready) begin
                        control_data  <= cmd_data[CMD_W-1 -: CTRL_NIBBLE_W];
                        shreg         <= cmd_data << CTRL_NIBBLE_W;
                        nib_left      <= NIB_LOAD;
                        control_valid <= 1'b1;
                        timeout_err   <= 1'b0;
                    end
                end
                ST_CFG: begin
                    if (tmr == '0) begin
                        start_config <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_SEND: begin
                    if (wd_expired) begin
                        control_valid <= 1'b0;
                        timeout_err   <= 1'b1;
                        tmr           <= GAP_LOAD;
                    end else if (last_hs) begin
                        control_valid <= 1'b0;
                        cmd_count     <= cmd_count + 1'b1;
                        tmr           <= GAP_LOAD;
                    end else if (nib_hs) begin
                        control_data <= shreg[CMD_W-1 -: CTRL_NIBBLE_W];
                        shreg        <= shreg << CTRL_NIBBLE_W;
                        nib_left     <= nib_left - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    control_valid <= 1'b0;
                    start_config  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_ctrl_sender.sv
// Bench for eth_ctrl_sender: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_eth_ctrl_sender;

    localparam int NIB   = 4;
    localparam int GAP   = 2;
    localparam int PULSE = 4;
    localparam int TMO   = 16;

    logic        clk_125 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cfg_req = 1'b0;
    logic        start_config;
    logic [3:0]  control_data;
    logic        control_valid;
    logic        control_ready = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [15:0] cmd_count;

    always #4 clk_125 = ~clk_125;

    eth_ctrl_sender #(
        .CMD_NIBBLES (NIB),
        .GAP_CYCLES  (GAP),
        .START_PULSE (PULSE),
        .TIMEOUT     (TMO)
    ) dut (
        .clk_125       (clk_125),
        .sys_rst_n     (sys_rst_n),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cfg_req       (cfg_req),
        .start_config  (start_config),
        .control_data  (control_data),
        .control_valid (control_valid),
        .control_ready (control_ready),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .cmd_count     (cmd_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 60) begin
            @(negedge clk_125);
            n++;
        end
        if (!cmd_ready) chk({name, "_ready_wait"}, 0, 1);
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, cmd_ready, start_config, control_data, control_valid,
                busy, timeout_err, cmd_count};
    endfunction

    // Offers one word; stalls control_ready for slen cycles while nibble snib
    // is shown. Reports nibbles in order, valid cycle count, first valid cycle
    // after the accept edge, and cycles from last handshake to cmd_ready.
    task automatic run_cmd(input logic [15:0] word, input int snib, input int slen,
                           output logic [15:0] got, output int vcyc,
                           output int first, output int rdy_gap);
        int n, st, c;
        got = '0; n = 0; st = 0; vcyc = 0; first = -1; rdy_gap = -1; c = 0;
        cmd_data = word;
        cmd_valid = 1'b1;
        control_ready = 1'b1;
        @(posedge clk_125);
        while (n < NIB && c < 60) begin
            @(negedge clk_125);
            c++;
            cmd_valid = 1'b0;
            if (control_valid) begin
                vcyc++;
                if (first < 0) first = c;
                if (n == snib && st < slen) begin
                    control_ready = 1'b0;
                    st++;
                end else begin
                    control_ready = 1'b1;
                    got = {got[11:0], control_data};
                    n++;
                end
            end else begin
                control_ready = 1'b1;
            end
        end
        for (int k = 1; k <= 10 && rdy_gap < 0; k++) begin
            @(negedge clk_125);
            if (cmd_ready) rdy_gap = k;
        end
        control_ready = 1'b0;
    endtask

    typedef struct {
        logic [15:0] word;
        int          stall_nib;
        int          stall_len;
        logic [15:0] exp_seq;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs[5];

    // transaction-level reference model for the random phase
    logic       mon_on = 1'b0;
    logic [3:0] q[$];
    int         exp_count = 0;
    int         stall = 0;
    int         sc_run = 0;
    logic       p_ready = 1'b0;
    logic       p_valid = 1'b0;
    logic [3:0] p_data = '0;

    initial forever begin
        @(posedge clk_125);
        #1;
        if (mon_on) begin
            if (p_valid && control_ready) begin
                stall = 0;
                if (q.size() == 0) begin
                    chk("rnd_spurious_nibble", 1, 0);
                end else begin
                    chk("rnd_nibble", p_data, q.pop_front());
                    if (q.size() == 0) begin
                        exp_count = (exp_count + 1) % 65536;
                        chk("rnd_count", cmd_count, exp_count);
                    end
                end
            end else if (p_valid) begin
                stall++;
                if (stall == TMO) begin
                    chk("rnd_timeout_valid", control_valid, 0);
                    chk("rnd_timeout_err", timeout_err, 1);
                    chk("rnd_timeout_count", cmd_count, exp_count);
                    q.delete();
                    stall = 0;
                end else begin
                    chk("rnd_hold_valid", control_valid, 1);
                    chk("rnd_hold_data", control_data, p_data);
                end
            end else begin
                stall = 0;
            end
            if (p_ready && cmd_valid) begin
                chk("rnd_single_inflight", q.size(), 0);
                for (int i = NIB - 1; i >= 0; i--) q.push_back(cmd_data[i*4 +: 4]);
                chk("rnd_err_clear", timeout_err, 0);
                chk("rnd_first_valid", control_valid, 1);
            end
            if (start_config) begin
                sc_run++;
            end else if (sc_run != 0) begin
                chk("rnd_pulse_width", sc_run, PULSE);
                sc_run = 0;
            end
        end
        p_ready = cmd_ready;
        p_valid = control_valid;
        p_data  = control_data;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got timeout want finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] got;
        int vcyc, first, rdy_gap, cnt, n, last_v, sc_first, sc_last, sc_cnt, rdy_after, pct;

        vecs[0] = '{16'hA5C3, -1, 0, 16'hA5C3, 4};
        vecs[1] = '{16'hA5C3,  1, 3, 16'hA5C3, 7};
        vecs[2] = '{16'h0000,  0, 2, 16'h0000, 6};
        vecs[3] = '{16'hFFFF,  3, 5, 16'hFFFF, 9};
        vecs[4] = '{16'h1234, -1, 0, 16'h1234, 4};

        // reset state
        repeat (3) @(negedge clk_125);
        chk("reset_outputs", all_outs(), 0);
        sys_rst_n = 1'b1;
        @(negedge clk_125);
        chk("reset_ready_rise", cmd_ready, 1);
        chk("reset_busy", busy, 0);

        // table-driven commands
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ready("vec");
            run_cmd(vecs[i].word, vecs[i].stall_nib, vecs[i].stall_len, got, vcyc, first, rdy_gap);
            cnt++;
            chk($sformatf("vec%0d_nibbles", i), got, vecs[i].exp_seq);
            chk($sformatf("vec%0d_valid_cycles", i), vcyc, vecs[i].exp_vcyc);
            chk($sformatf("vec%0d_first_latency", i), first, 1);
            chk($sformatf("vec%0d_ready_gap", i), rdy_gap, GAP + 1);
            chk($sformatf("vec%0d_count", i), cmd_count, cnt);
        end

        // watchdog: receiver never ready
        wait_ready("tmo");
        cmd_data = 16'hBEEF;
        cmd_valid = 1'b1;
        control_ready = 1'b0;
        @(posedge clk_125);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_125);
            cmd_valid = 1'b0;
            if (control_valid) n++;
            else break;
        end
        chk("tmo_valid_cycles", n, TMO);
        chk("tmo_err_set", timeout_err, 1);
        chk("tmo_count_unchanged", cmd_count, cnt);
        wait_ready("tmo_next");
        run_cmd(16'h0F1E, -1, 0, got, vcyc, first, rdy_gap);
        cnt++;
        chk("tmo_next_nibbles", got, 16'h0F1E);
        chk("tmo_err_cleared", timeout_err, 0);
        chk("tmo_next_count", cmd_count, cnt);

        // config request coincident with a command handshake
        wait_ready("cfg");
        cmd_data = 16'h9E17;
        cmd_valid = 1'b1;
        cfg_req = 1'b1;
        control_ready = 1'b1;
        @(posedge clk_125);
        got = '0; last_v = -1; sc_first = -1; sc_last = -1; sc_cnt = 0; rdy_after = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_125);
            cmd_valid = 1'b0;
            cfg_req = 1'b0;
            if (control_valid) begin
                got = {got[11:0], control_data};
                last_v = c;
            end
            if (start_config) begin
                sc_cnt++;
                if (sc_first < 0) sc_first = c;
                sc_last = c;
            end
            if (cmd_ready && rdy_after < 0) rdy_after = c;
        end
        control_ready = 1'b0;
        cnt++;
        chk("cfg_cmd_nibbles", got, 16'h9E17);
        chk("cfg_pulse_width", sc_cnt, PULSE);
        chk("cfg_after_gap", (sc_first - last_v) > GAP, 1);
        chk("cfg_ready_return", rdy_after, sc_last + 1);
        chk("cfg_count", cmd_count, cnt);

        // reset while nibble 3 is on the port
        wait_ready("rst");
        cmd_data = 16'hFACE;
        cmd_valid = 1'b1;
        control_ready = 1'b1;
        @(posedge clk_125);
        @(negedge clk_125);
        cmd_valid = 1'b0;
        @(negedge clk_125);
        @(negedge clk_125);
        chk("rst_mid_nibble3", {control_valid, control_data}, 5'h1C);
        control_ready = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async_valid", control_valid, 0);
        chk("rst_async_outputs", all_outs(), 0);
        @(negedge clk_125);
        sys_rst_n = 1'b1;
        wait_ready("rst_after");
        run_cmd(16'h1234, -1, 0, got, vcyc, first, rdy_gap);
        chk("rst_after_nibbles", got, 16'h1234);
        chk("rst_after_count", cmd_count, 1);

        // randomized traffic against the model
        @(negedge clk_125);
        sys_rst_n = 1'b0;
        @(negedge clk_125);
        sys_rst_n = 1'b1;
        mon_on = 1'b1;
        pct = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_125);
            if (cyc % 40 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 5;
                    1:       pct = 60;
                    default: pct = 100;
                endcase
            end
            control_ready = ($urandom_range(0, 99) < pct);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_data = 16'($urandom);
            cfg_req = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk_125);
        cmd_valid = 1'b0;
        cfg_req = 1'b0;
        control_ready = 1'b1;
        repeat (60) @(negedge clk_125);
        mon_on = 1'b0;
        chk("rnd_drain_queue", q.size(), 0);
        chk("rnd_drain_busy", busy, 0);
        chk("rnd_final_count", cmd_count, exp_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
